pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: control unit for an in-order RV32I pipeline.
//
// Tracks NSTAGE post-decode slots (slot 0 = EX, slot 1 = MEM, slot NSTAGE-1 = WB).
// Decodes slot 0 into ALU/branch controls, resolves operand forwarding from
// older slots, detects load-use hazards against the decode-stage instruction,
// and drives memory and write-back controls from slots 1 and NSTAGE-1.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   inst_i, inst_valid_i          decode-stage instruction
//   br_eq_i, br_lt_i              branch comparator results for slot 0
//   br_un_o                       unsigned compare for slot 0
//   fwd_a_sel_o, fwd_b_sel_o      0 = register file, k = result of slot k
//   a_pc_sel_o, b_imm_sel_o       ALU A = PC, ALU B = immediate
//   alu_op_o                      ALU operation for slot 0
//   mem_we_o, mem_re_o            slot-1 store / load
//   wb_sel_o                      WB source: 0 ALU, 1 memory, 2 PC+4
//   reg_w_en_o, reg_w_addr_o      WB-slot register write
//   pc_sel_o, flush_o, stall_o    redirect, discard inst_i, hold PC/inst_i
//   illegal_o                     pulse when an unknown opcode is dropped
//   stall_cnt_o, flush_cnt_o      saturating event counters
// Every output is forced to 0 while rst is high.
module pipe_ctrl #(
    parameter int NSTAGE       = 3,
    parameter int LOAD_FWD_MIN = 2,
    parameter int CNT_W        = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               inst_i,
    input  logic                      inst_valid_i,
    input  logic                      br_eq_i,
    input  logic                      br_lt_i,
    output logic                      br_un_o,
    output logic [$clog2(NSTAGE)-1:0] fwd_a_sel_o,
    output logic [$clog2(NSTAGE)-1:0] fwd_b_sel_o,
    output logic                      a_pc_sel_o,
    output logic                      b_imm_sel_o,
    output logic [3:0]                alu_op_o,
    output logic                      mem_we_o,
    output logic                      mem_re_o,
    output logic [1:0]                wb_sel_o,
    output logic                      reg_w_en_o,
    output logic [4:0]                reg_w_addr_o,
    output logic                      pc_sel_o,
    output logic                      stall_o,
    output logic                      flush_o,
    output logic                      illegal_o,
    output logic [CNT_W-1:0]          stall_cnt_o,
    output logic [CNT_W-1:0]          flush_cnt_o
);

    localparam int SW = $clog2(NSTAGE);
    localparam int WB = NSTAGE - 1;

    localparam logic [6:0] OP_REGREG = 7'b0110011;
    localparam logic [6:0] OP_REGIMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_SLL  = 4'd4;
    localparam logic [3:0] ALU_SRL  = 4'd5;
    localparam logic [3:0] ALU_OR   = 4'd6;
    localparam logic [3:0] ALU_XOR  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;
    localparam logic [3:0] ALU_SUB  = 4'd12;

    function automatic logic is_legal(input logic [6:0] op);
        return (op == OP_REGREG) || (op == OP_REGIMM) || (op == OP_LOAD) ||
               (op == OP_STORE)  || (op == OP_BRANCH) || (op == OP_JAL)  ||
               (op == OP_JALR)   || (op == OP_LUI)    || (op == OP_AUIPC);
    endfunction

    function automatic logic writes_rd(input logic [6:0] op);
        return (op == OP_REGREG) || (op == OP_REGIMM) || (op == OP_LOAD) ||
               (op == OP_JAL)    || (op == OP_JALR)   || (op == OP_LUI)  ||
               (op == OP_AUIPC);
    endfunction

    function automatic logic reads_rs1(input logic [6:0] op);
        return (op == OP_REGREG) || (op == OP_REGIMM) || (op == OP_LOAD) ||
               (op == OP_STORE)  || (op == OP_BRANCH) || (op == OP_JALR);
    endfunction

    function automatic logic reads_rs2(input logic [6:0] op);
        return (op == OP_REGREG) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

    logic [31:0]       slot_inst_q [NSTAGE];
    logic [31:0]       slot_inst_d [NSTAGE];
    logic [NSTAGE-1:0] vld_q, vld_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic [NSTAGE-1:0] wr_any;     // slot holds a real write to a nonzero rd
    logic [NSTAGE-1:0] wr_load;    // ... and that write comes from a load
    logic [NSTAGE-1:0] fwd_ok;     // slot may supply a forwarded result

    logic [6:0] op0;
    logic [2:0] f3_0;
    logic       v0;
    logic [3:0] alu_raw;
    logic       br_un_raw, a_pc_raw, b_imm_raw, pc_sel_raw;
    logic [SW-1:0] fwd_a_raw, fwd_b_raw;

    logic       legal_i, ld_late_a, ld_late_b;
    logic       stall_raw, flush_raw, stall_eff;

    assign op0  = slot_inst_q[0][6:0];
    assign f3_0 = slot_inst_q[0][14:12];
    assign v0   = vld_q[0];

    always_comb begin
        for (int k = 0; k < NSTAGE; k++) begin
            wr_any[k]  = vld_q[k] && writes_rd(slot_inst_q[k][6:0]) &&
                         (slot_inst_q[k][11:7] != 5'd0);
            wr_load[k] = wr_any[k] && (slot_inst_q[k][6:0] == OP_LOAD);
            // A load still short of the data return point cannot forward.
            fwd_ok[k]  = wr_any[k] && !(wr_load[k] && (k < LOAD_FWD_MIN));
        end
    end

    // Slot-0 decode
    always_comb begin
        alu_raw    = ALU_NOP;
        br_un_raw  = 1'b0;
        a_pc_raw   = 1'b0;
        b_imm_raw  = 1'b0;
        pc_sel_raw = 1'b0;
        if (v0) begin
            b_imm_raw = (op0 != OP_REGREG);
            a_pc_raw  = (op0 == OP_BRANCH) || (op0 == OP_JAL) || (op0 == OP_AUIPC);
            unique case (op0)
                OP_REGREG, OP_REGIMM: begin
                    unique case (f3_0)
                        3'b000: alu_raw = (op0 == OP_REGREG && slot_inst_q[0][30]) ?
                                          ALU_SUB : ALU_ADD;
                        3'b001: alu_raw = ALU_SLL;
                        3'b010: alu_raw = ALU_SLT;
                        3'b011: alu_raw = ALU_SLTU;
                        3'b100: alu_raw = ALU_XOR;
                        3'b101: alu_raw = slot_inst_q[0][30] ? ALU_SRA : ALU_SRL;
                        3'b110: alu_raw = ALU_OR;
                        default: alu_raw = ALU_AND;
                    endcase
                end
                OP_LUI: alu_raw = ALU_LUI;
                OP_BRANCH: begin
                    alu_raw   = ALU_ADD;
                    br_un_raw = (f3_0[2:1] == 2'b11);
                    unique case (f3_0)
                        3'b000:         pc_sel_raw = br_eq_i;
                        3'b001:         pc_sel_raw = !br_eq_i;
                        3'b100, 3'b110: pc_sel_raw = br_lt_i;
                        3'b101, 3'b111: pc_sel_raw = !br_lt_i;
                        default:        pc_sel_raw = 1'b0;
                    endcase
                end
                OP_JAL, OP_JALR: begin
                    alu_raw    = ALU_ADD;
                    pc_sel_raw = 1'b1;
                end
                default: alu_raw = ALU_ADD;
            endcase
        end
    end

    // Forwarding: scan oldest to youngest so the lowest matching slot wins.
    always_comb begin
        fwd_a_raw = '0;
        fwd_b_raw = '0;
        for (int k = NSTAGE - 1; k >= 1; k--) begin
            if (fwd_ok[k] && slot_inst_q[k][11:7] == slot_inst_q[0][19:15])
                fwd_a_raw = SW'(k);
            if (fwd_ok[k] && slot_inst_q[k][11:7] == slot_inst_q[0][24:20])
                fwd_b_raw = SW'(k);
        end
        if (!(v0 && reads_rs1(op0))) fwd_a_raw = '0;
        if (!(v0 && reads_rs2(op0))) fwd_b_raw = '0;
    end

    // Load-use: the youngest writer of each source decides. If it is a load
    // that would still sit below LOAD_FWD_MIN once inst_i enters slot 0, hold.
    always_comb begin
        ld_late_a = 1'b0;
        ld_late_b = 1'b0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (wr_any[k] && slot_inst_q[k][11:7] == inst_i[19:15])
                ld_late_a = wr_load[k] && (k + 2 <= LOAD_FWD_MIN);
            if (wr_any[k] && slot_inst_q[k][11:7] == inst_i[24:20])
                ld_late_b = wr_load[k] && (k + 2 <= LOAD_FWD_MIN);
        end
    end

    assign legal_i   = is_legal(inst_i[6:0]);
    assign stall_raw = inst_valid_i && legal_i &&
                       ((reads_rs1(inst_i[6:0]) && ld_late_a) ||
                        (reads_rs2(inst_i[6:0]) && ld_late_b));
    assign flush_raw = v0 && pc_sel_raw;
    assign stall_eff = stall_raw && !flush_raw;

    // Slots 1.. always advance; only the slot-0 source changes.
    always_comb begin
        slot_inst_d[0] = inst_i;
        vld_d[0]       = inst_valid_i && legal_i && !stall_eff && !flush_raw;
        for (int k = 1; k < NSTAGE; k++) begin
            slot_inst_d[k] = slot_inst_q[k-1];
            vld_d[k]       = vld_q[k-1];
        end
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_eff && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush_raw && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            for (int k = 0; k < NSTAGE; k++) slot_inst_q[k] <= '0;
        end else begin
            vld_q       <= vld_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            slot_inst_q <= slot_inst_d;
        end
    end

    always_comb begin
        br_un_o      = 1'b0;
        fwd_a_sel_o  = '0;
        fwd_b_sel_o  = '0;
        a_pc_sel_o   = 1'b0;
        b_imm_sel_o  = 1'b0;
        alu_op_o     = ALU_NOP;
        mem_we_o     = 1'b0;
        mem_re_o     = 1'b0;
        wb_sel_o     = 2'd0;
        reg_w_en_o   = 1'b0;
        reg_w_addr_o = 5'd0;
        pc_sel_o     = 1'b0;
        stall_o      = 1'b0;
        flush_o      = 1'b0;
        illegal_o    = 1'b0;
        stall_cnt_o  = '0;
        flush_cnt_o  = '0;
        if (!rst) begin
            br_un_o      = br_un_raw;
            fwd_a_sel_o  = fwd_a_raw;
            fwd_b_sel_o  = fwd_b_raw;
            a_pc_sel_o   = a_pc_raw;
            b_imm_sel_o  = b_imm_raw;
            alu_op_o     = alu_raw;
            mem_we_o     = vld_q[1] && (slot_inst_q[1][6:0] == OP_STORE);
            mem_re_o     = vld_q[1] && (slot_inst_q[1][6:0] == OP_LOAD);
            if (vld_q[WB] && slot_inst_q[WB][6:0] == OP_LOAD)
                wb_sel_o = 2'd1;
            else if (vld_q[WB] && (slot_inst_q[WB][6:0] == OP_JAL ||
                                   slot_inst_q[WB][6:0] == OP_JALR))
                wb_sel_o = 2'd2;
            reg_w_en_o   = wr_any[WB];
            reg_w_addr_o = slot_inst_q[WB][11:7];
            pc_sel_o     = pc_sel_raw;
            stall_o      = stall_eff;
            flush_o      = flush_raw;
            illegal_o    = inst_valid_i && !legal_i && !flush_raw;
            stall_cnt_o  = stall_cnt_q;
            flush_cnt_o  = flush_cnt_q;
        end
    end

endmodule
